// File: rtl/usbdev_pkg.sv
// usbdev_pkg: PID codes, token encodings and endpoint FSM states shared by the endpoint controller
package usbdev_pkg;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [1:0] TOK_OUT   = 2'b00;
  localparam logic [1:0] TOK_IN    = 2'b01;
  localparam logic [1:0] TOK_SETUP = 2'b10;
  typedef enum logic [2:0] {IDLE, RX_DATA, TX_HS, TX_DATA, WAIT_ACK} state_t;
endpackage

// File: rtl/usbdev_ep_flags.sv
// usbdev_ep_flags: per-endpoint ready flags and data toggles; host-side clears beat CPU arms, toggle_clr beats everything
module usbdev_ep_flags #(
  parameter int NUM_EP = 4,
  parameter int EPW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EPW-1:0]    cur_ep,
  input  logic [NUM_EP-1:0] ep_in_arm,
  input  logic [NUM_EP-1:0] ep_out_arm,
  input  logic [NUM_EP-1:0] ep_toggle_clr,
  input  logic              in_clr,
  input  logic              in_flip,
  input  logic              out_clr,
  input  logic              out_flip,
  input  logic              setup_set,
  output logic [NUM_EP-1:0] in_rdy,
  output logic [NUM_EP-1:0] out_rdy,
  output logic [NUM_EP-1:0] in_tog,
  output logic [NUM_EP-1:0] out_tog
);
  logic [NUM_EP-1:0] sel;
  assign sel = NUM_EP'(1) << cur_ep;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_rdy  <= '0;
      out_rdy <= '0;
      in_tog  <= '0;
      out_tog <= '0;
    end else begin
      in_rdy  <= (in_rdy | ep_in_arm) & ~(sel & {NUM_EP{in_clr}});
      out_rdy <= (out_rdy | ep_out_arm) & ~(sel & {NUM_EP{out_clr}});
      in_tog  <= ~ep_toggle_clr & ((in_tog ^ (sel & {NUM_EP{in_flip}})) | (sel & {NUM_EP{setup_set}}));
      out_tog <= ~ep_toggle_clr & ((out_tog ^ (sel & {NUM_EP{out_flip}})) | (sel & {NUM_EP{setup_set}}));
    end
endmodule

// File: rtl/usbdev_ep_ctrl.sv
// usbdev_ep_ctrl: per-token response sequencer for the full-speed SIE; one transaction in flight at a time
module usbdev_ep_ctrl
  import usbdev_pkg::*;
#(
  parameter int NUM_EP      = 4,
  parameter int EPW         = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tok_valid,
  input  logic [1:0]        tok_type,
  input  logic [EPW-1:0]    tok_ep,
  input  logic              rx_pkt_valid,
  input  logic              rx_pkt_ok,
  input  logic              rx_pkt_data1,
  input  logic              rx_ack,
  output logic              tx_req,
  output logic [3:0]        tx_pid,
  input  logic              tx_done,
  input  logic [NUM_EP-1:0] ep_in_arm,
  input  logic [NUM_EP-1:0] ep_out_arm,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] ep_toggle_clr,
  output logic [NUM_EP-1:0] ep_in_rdy,
  output logic [NUM_EP-1:0] ep_out_rdy,
  output logic [NUM_EP-1:0] in_done,
  output logic [NUM_EP-1:0] out_done,
  output logic              setup_rcvd,
  output logic [EPW-1:0]    cur_ep,
  output logic              busy
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_n;
  logic [1:0] tok, tok_n;
  logic [EPW-1:0] cur_ep_n;
  logic tx_req_n;
  logic [3:0] tx_pid_n;
  logic [CW-1:0] cnt, cnt_n;
  logic in_clr, in_flip, out_clr, out_flip, setup_set;
  logic [NUM_EP-1:0] in_tog, out_tog, sel;
  logic stall, in_r, out_r, in_t, out_t, out_match, abort;
  usbdev_ep_flags #(.NUM_EP(NUM_EP), .EPW(EPW)) u_flags (
    .clk(clk), .rst(rst), .cur_ep(cur_ep),
    .ep_in_arm(ep_in_arm), .ep_out_arm(ep_out_arm), .ep_toggle_clr(ep_toggle_clr),
    .in_clr(in_clr), .in_flip(in_flip), .out_clr(out_clr), .out_flip(out_flip), .setup_set(setup_set),
    .in_rdy(ep_in_rdy), .out_rdy(ep_out_rdy), .in_tog(in_tog), .out_tog(out_tog)
  );
  assign sel        = NUM_EP'(1) << cur_ep;
  assign stall      = ep_stall[cur_ep];
  assign in_r       = ep_in_rdy[cur_ep];
  assign out_r      = ep_out_rdy[cur_ep];
  assign in_t       = in_tog[cur_ep];
  assign out_t      = out_tog[cur_ep];
  assign out_match  = out_r && (rx_pkt_data1 == out_t);
  assign in_done    = sel & {NUM_EP{in_flip}};
  assign out_done   = sel & {NUM_EP{out_flip}};
  assign setup_rcvd = setup_set;
  assign busy       = state != IDLE;
  // A new token restarts from IDLE in states where nothing is being transmitted
  assign abort      = tok_valid && (state == IDLE || state == RX_DATA || state == WAIT_ACK);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      tok    <= TOK_OUT;
      cur_ep <= '0;
      tx_req <= 1'b0;
      tx_pid <= 4'b0000;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      tok    <= tok_n;
      cur_ep <= cur_ep_n;
      tx_req <= tx_req_n;
      tx_pid <= tx_pid_n;
      cnt    <= cnt_n;
    end
  always_comb begin
    state_n   = state;
    tok_n     = tok;
    cur_ep_n  = cur_ep;
    tx_req_n  = tx_req;
    tx_pid_n  = tx_pid;
    cnt_n     = cnt;
    in_clr    = 1'b0;
    in_flip   = 1'b0;
    out_clr   = 1'b0;
    out_flip  = 1'b0;
    setup_set = 1'b0;
    case (state)
      RX_DATA: if (rx_pkt_valid) begin
        state_n   = rx_pkt_ok ? TX_HS : IDLE;
        tx_req_n  = rx_pkt_ok;
        setup_set = rx_pkt_ok && tok == TOK_SETUP;
        out_flip  = rx_pkt_ok && tok != TOK_SETUP && !stall && out_match;
        out_clr   = setup_set || out_flip;
        tx_pid_n  = (tok == TOK_SETUP) ? PID_ACK : stall ? PID_STALL : !out_r ? PID_NAK : PID_ACK;
      end
      TX_HS: if (tx_done) begin
        state_n  = IDLE;
        tx_req_n = 1'b0;
      end
      TX_DATA: if (!tx_req) begin
        tx_req_n = 1'b1;
        tx_pid_n = stall ? PID_STALL : !in_r ? PID_NAK : in_t ? PID_DATA1 : PID_DATA0;
        state_n  = (stall || !in_r) ? TX_HS : TX_DATA;
      end else if (tx_done) begin
        tx_req_n = 1'b0;
        state_n  = WAIT_ACK;
        cnt_n    = '0;
      end
      WAIT_ACK: begin
        in_flip = rx_ack;
        in_clr  = rx_ack;
        state_n = (rx_ack || cnt == CW'(ACK_TIMEOUT - 1)) ? IDLE : WAIT_ACK;
        cnt_n   = cnt + CW'(1);
      end
      default: ;
    endcase
    if (abort) begin
      in_clr    = 1'b0;
      in_flip   = 1'b0;
      out_clr   = 1'b0;
      out_flip  = 1'b0;
      setup_set = 1'b0;
      tx_req_n  = 1'b0;
      state_n   = (tok_type == TOK_IN) ? TX_DATA : (tok_type == TOK_OUT || tok_type == TOK_SETUP) ? RX_DATA : IDLE;
      tok_n     = (tok_type == 2'b11) ? tok : tok_type;
      cur_ep_n  = (tok_type == 2'b11) ? cur_ep : tok_ep;
    end
  end
endmodule

// File: tb/tb_usbdev_ep_ctrl.sv
// tb_usbdev_ep_ctrl: scoreboarded check of handshake PIDs, flags, toggles and pulses of usbdev_ep_ctrl
module tb_usbdev_ep_ctrl;
  import usbdev_pkg::*;
  localparam int NUM_EP = 4;
  localparam int EPW = 2;
  logic clk = 0, rst = 1;
  logic tok_valid = 0, rx_pkt_valid = 0, rx_pkt_ok = 0, rx_pkt_data1 = 0, rx_ack = 0, tx_done = 0;
  logic [1:0] tok_type = 0;
  logic [EPW-1:0] tok_ep = 0;
  logic [NUM_EP-1:0] ep_in_arm = 0, ep_out_arm = 0, ep_stall = 0, ep_toggle_clr = 0;
  logic tx_req, setup_rcvd, busy;
  logic [3:0] tx_pid;
  logic [NUM_EP-1:0] ep_in_rdy, ep_out_rdy, in_done, out_done;
  logic [EPW-1:0] cur_ep;
  int checks = 0, errors = 0;
  logic [3:0] exp_q[$];
  logic [NUM_EP-1:0] in_seen = 0, out_seen = 0;
  logic setup_seen = 0, req_d = 0;

  usbdev_ep_ctrl #(.NUM_EP(NUM_EP), .EPW(EPW), .ACK_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_type(tok_type), .tok_ep(tok_ep),
    .rx_pkt_valid(rx_pkt_valid), .rx_pkt_ok(rx_pkt_ok), .rx_pkt_data1(rx_pkt_data1), .rx_ack(rx_ack),
    .tx_req(tx_req), .tx_pid(tx_pid), .tx_done(tx_done),
    .ep_in_arm(ep_in_arm), .ep_out_arm(ep_out_arm), .ep_stall(ep_stall), .ep_toggle_clr(ep_toggle_clr),
    .ep_in_rdy(ep_in_rdy), .ep_out_rdy(ep_out_rdy), .in_done(in_done), .out_done(out_done),
    .setup_rcvd(setup_rcvd), .cur_ep(cur_ep), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each transmit request is matched against the next expected PID
  initial forever begin
    @(negedge clk);
    if (tx_req && !req_d) begin
      chk("tx_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) chk("tx_pid", {28'd0, tx_pid}, {28'd0, exp_q.pop_front()});
    end
    req_d = tx_req;
    in_seen = in_seen | in_done;
    out_seen = out_seen | out_done;
    setup_seen = setup_seen | setup_rcvd;
  end

  initial forever begin
    @(negedge clk);
    if (tx_req) begin
      @(posedge clk); #1 tx_done = 1;
      @(posedge clk); #1 tx_done = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr_seen();
    in_seen = 0; out_seen = 0; setup_seen = 0;
  endtask

  task automatic token(input logic [1:0] t, input int ep);
    tok_valid = 1; tok_type = t; tok_ep = EPW'(ep);
    cyc();
    tok_valid = 0;
  endtask

  task automatic pkt(input logic ok, input logic d1, input logic [NUM_EP-1:0] arm, input logic [NUM_EP-1:0] tclr);
    rx_pkt_valid = 1; rx_pkt_ok = ok; rx_pkt_data1 = d1; ep_out_arm = arm; ep_toggle_clr = tclr;
    cyc();
    rx_pkt_valid = 0; ep_out_arm = 0; ep_toggle_clr = 0;
  endtask

  task automatic arm(input logic [NUM_EP-1:0] in_m, input logic [NUM_EP-1:0] out_m);
    ep_in_arm = in_m; ep_out_arm = out_m;
    cyc();
    ep_in_arm = 0; ep_out_arm = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin cyc(); n++; end
    chk({tag, "_idle"}, {31'd0, busy}, 0);
  endtask

  task automatic wait_fall(input string tag);
    int n = 0;
    while (!tx_req && n < 50) begin cyc(); n++; end
    while (tx_req && n < 100) begin cyc(); n++; end
    chk({tag, "_txfall"}, {31'd0, tx_req}, 0);
  endtask

  task automatic in_acked(input int ep, input logic [3:0] pid, input string tag);
    clr_seen();
    exp_q.push_back(pid);
    token(TOK_IN, ep);
    wait_fall(tag);
    rx_ack = 1; cyc(); rx_ack = 0;
    wait_idle(tag);
    chk({tag, "_in_done"}, {28'd0, in_seen}, 32'(1 << ep));
    chk({tag, "_in_rdy"}, {28'd0, ep_in_rdy[ep]}, 0);
  endtask

  task automatic out_txn(input int ep, input logic d1, input logic [3:0] pid, input logic [NUM_EP-1:0] parm,
                         input logic [NUM_EP-1:0] tclr, input logic [NUM_EP-1:0] exp_done, input string tag);
    clr_seen();
    exp_q.push_back(pid);
    token(TOK_OUT, ep);
    pkt(1, d1, parm, tclr);
    wait_idle(tag);
    chk({tag, "_out_done"}, {28'd0, out_seen}, {28'd0, exp_done});
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {7'd0, tx_req, tx_pid, ep_in_rdy, ep_out_rdy, in_done, out_done, setup_rcvd, cur_ep, busy}, 0);
    @(posedge clk); #1 rst = 0;
    cyc();
    // OUT ep1: DATA0 accepted, duplicate DATA0 re-ACKed only, then DATA1 accepted
    arm(0, 4'b0010);
    chk("out_arm", {28'd0, ep_out_rdy}, 4'b0010);
    out_txn(1, 0, PID_ACK, 0, 0, 4'b0010, "out1");
    chk("out1_rdy", {28'd0, ep_out_rdy}, 0);
    chk("out1_cur_ep", {30'd0, cur_ep}, 1);
    arm(0, 4'b0010);
    out_txn(1, 0, PID_ACK, 0, 0, 4'b0000, "dup");
    chk("dup_rdy", {28'd0, ep_out_rdy}, 4'b0010);
    out_txn(1, 1, PID_ACK, 0, 0, 4'b0010, "out1b");
    chk("out1b_rdy", {28'd0, ep_out_rdy}, 0);
    out_txn(1, 0, PID_NAK, 0, 0, 4'b0000, "out_nak");
    // IN ep2: NAK when empty, then DATA0/DATA1 alternate on ACK
    clr_seen();
    exp_q.push_back(PID_NAK);
    token(TOK_IN, 2);
    wait_idle("in_nak");
    chk("in_nak_done", {28'd0, in_seen}, 0);
    arm(4'b0100, 0);
    chk("in_arm", {28'd0, ep_in_rdy}, 4'b0100);
    in_acked(2, PID_DATA0, "in_d0");
    arm(4'b0100, 0);
    in_acked(2, PID_DATA1, "in_d1");
    // No host ACK: leave after exactly ACK_TIMEOUT cycles, retry resends the same toggle
    arm(4'b0100, 0);
    clr_seen();
    exp_q.push_back(PID_DATA0);
    token(TOK_IN, 2);
    wait_fall("to");
    n = 0;
    while (busy && n < 200) begin cyc(); n++; end
    chk("timeout_cycles", n, 64);
    chk("timeout_in_rdy", {28'd0, ep_in_rdy}, 4'b0100);
    chk("timeout_in_done", {28'd0, in_seen}, 0);
    in_acked(2, PID_DATA0, "retry");
    // Stalled ep3: OUT stalls, SETUP still ACKed, IN stalls, unstalled IN uses DATA1
    ep_stall = 4'b1000;
    arm(0, 4'b1000);
    out_txn(3, 0, PID_STALL, 0, 0, 4'b0000, "stall_out");
    chk("stall_out_rdy", {28'd0, ep_out_rdy}, 4'b1000);
    clr_seen();
    exp_q.push_back(PID_ACK);
    token(TOK_SETUP, 3);
    pkt(1, 0, 0, 0);
    wait_idle("setup");
    chk("setup_pulse", {31'd0, setup_seen}, 1);
    chk("setup_rdy", {28'd0, ep_out_rdy}, 0);
    chk("setup_cur_ep", {30'd0, cur_ep}, 3);
    arm(4'b1000, 0);
    exp_q.push_back(PID_STALL);
    token(TOK_IN, 3);
    wait_idle("stall_in");
    chk("stall_in_rdy", {28'd0, ep_in_rdy}, 4'b1000);
    ep_stall = 0;
    in_acked(3, PID_DATA1, "setup_tog");
    // Bad CRC: silent return, no flag change
    arm(0, 4'b0010);
    token(TOK_OUT, 1);
    pkt(0, 0, 0, 0);
    chk("crc_busy", {31'd0, busy}, 0);
    repeat (3) cyc();
    chk("crc_rdy", {28'd0, ep_out_rdy}, 4'b0010);
    // toggle_clr beats the flip; host clear beats a same-cycle arm, other endpoints still arm
    out_txn(1, 0, PID_ACK, 0, 4'b0010, 4'b0010, "tclr");
    arm(0, 4'b0010);
    out_txn(1, 0, PID_ACK, 4'b0011, 0, 4'b0010, "armclr");
    chk("armclr_rdy", {28'd0, ep_out_rdy}, 4'b0001);
    // Async reset while waiting for the host ACK
    arm(4'b0100, 0);
    exp_q.push_back(PID_DATA1);
    token(TOK_IN, 2);
    wait_fall("arst");
    repeat (5) cyc();
    chk("arst_busy_before", {31'd0, busy}, 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("arst_outputs", {7'd0, tx_req, tx_pid, ep_in_rdy, ep_out_rdy, in_done, out_done, setup_rcvd, cur_ep, busy}, 0);
    @(posedge clk); #1 rst = 0;
    cyc();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
